proc_hier_top: RTL and testbench

//  Top of the processor hierarchy for the 16-bit WISC-SP13 single-cycle core. Instantiates
//  the core as p0 (sub-instances fetch0, decode0.regFile0, memory0), taps its architectural

---
 rtl/proc_hier_top_if.sv | 31 +++
 rtl/proc_hier_top.sv | 275 +++++++++++++++++++++++++++
 tb/tb_proc_hier_top.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/proc_hier_top_if.sv
// Commit-trace bus of the WISC-SP13 processor top: architectural taps plus
// commit classification, cycle/retire counters and the sticky halt flag.
interface proc_hier_top_if #(
    parameter int CNT_W = 32
);
    logic             err;
    logic [15:0]      pc;
    logic [15:0]      inst;
    logic             reg_write;
    logic [2:0]       write_reg;
    logic [15:0]      write_data;
    logic             mem_read;
    logic             mem_write;
    logic [15:0]      mem_addr;
    logic [15:0]      mem_data;
    logic             halt;
    logic             halted;
    logic [2:0]       trace_kind;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] inst_count;

    modport master (
        output err, pc, inst, reg_write, write_reg, write_data, mem_read, mem_write,
               mem_addr, mem_data, halt, halted, trace_kind, cycle_count, inst_count
    );

    modport slave (
        input  err, pc, inst, reg_write, write_reg, write_data, mem_read, mem_write,
               mem_addr, mem_data, halt, halted, trace_kind, cycle_count, inst_count
    );
endinterface

// File: rtl/proc_hier_top.sv
// WISC-SP13 single-cycle core (p0: fetch0, decode0.regFile0, memory0) and the
// trace top that exposes its commit signals, counters and commit class.
module fetch #(
    parameter int                        IMEM_WORDS = 32,
    parameter logic [16*IMEM_WORDS-1:0]  PROG       = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_next_pc,
    output logic [15:0] currPC,
    output logic [15:0] instr,
    output logic        halt
);
    localparam int AW = $clog2(IMEM_WORDS);

    logic [15:0]   r_pc;
    logic [AW-1:0] w_idx;
    logic          w_unused_pc;

    always_ff @(posedge clk) begin
        if (rst) r_pc <= 16'h0000;
        else     r_pc <= i_next_pc;
    end

    // Program ROM is word addressed; the byte bit and high bits beyond the ROM are ignored.
    assign w_idx       = r_pc[AW:1];
    assign w_unused_pc = ^{r_pc[15:AW+1], r_pc[0]};
    assign currPC      = r_pc;
    assign instr       = PROG[{w_idx, 4'b0000} +: 16];
    assign halt        = (instr[15:11] == 5'b00000);
endmodule

module regFile (
    input  logic        clk,
    input  logic [2:0]  read1regsel,
    input  logic [2:0]  read2regsel,
    input  logic [2:0]  writeregsel,
    input  logic [15:0] writedata,
    input  logic        write,
    output logic [15:0] read1data,
    output logic [15:0] read2data
);
    logic [15:0] r_regs [0:7];

    always_ff @(posedge clk) begin
        if (write) r_regs[writeregsel] <= writedata;
    end

    assign read1data = r_regs[read1regsel];
    assign read2data = r_regs[read2regsel];
endmodule

module decode (
    input  logic        clk,
    input  logic [15:0] i_instr,
    input  logic [15:0] i_writedata,
    output logic [15:0] o_rs_val,
    output logic [15:0] o_rt_val,
    output logic        o_reg_write,
    output logic [2:0]  o_wsel,
    output logic        o_mem_en,
    output logic        o_mem_wr,
    output logic        o_err
);
    logic [4:0] w_op;
    logic       w_unused_func;

    assign w_op          = i_instr[15:11];
    assign w_unused_func = ^i_instr[1:0];

    always_comb begin
        o_reg_write = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_wr    = 1'b0;
        o_err       = 1'b0;
        o_wsel      = i_instr[7:5];
        case (w_op)
            5'b00000, 5'b00001, 5'b01100, 5'b01101,
            5'b01110, 5'b01111, 5'b00100, 5'b00101: begin end
            5'b01000, 5'b01001, 5'b01010, 5'b01011: o_reg_write = 1'b1;
            5'b10000: begin o_mem_en = 1'b1; o_mem_wr = 1'b1; end
            5'b10001: begin o_mem_en = 1'b1; o_reg_write = 1'b1; end
            // stu writes the updated base address back into Rs
            5'b10011: begin
                o_mem_en = 1'b1; o_mem_wr = 1'b1; o_reg_write = 1'b1; o_wsel = i_instr[10:8];
            end
            5'b11000, 5'b10010: begin o_reg_write = 1'b1; o_wsel = i_instr[10:8]; end
            5'b00110, 5'b00111: begin o_reg_write = 1'b1; o_wsel = 3'd7; end
            5'b11011: begin o_reg_write = 1'b1; o_wsel = i_instr[4:2]; end
            default:  o_err = 1'b1;
        endcase
    end

    regFile regFile0 (
        .clk         (clk),
        .read1regsel (i_instr[10:8]),
        .read2regsel (i_instr[7:5]),
        .writeregsel (o_wsel),
        .writedata   (i_writedata),
        .write       (o_reg_write),
        .read1data   (o_rs_val),
        .read2data   (o_rt_val)
    );
endmodule

module memory (
    input  logic        clk,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out
);
    logic [15:0] r_mem [0:255];
    logic [7:0]  w_idx;
    logic        w_unused_addr;

    assign w_idx         = addr[8:1];
    assign w_unused_addr = ^{addr[15:9], addr[0]};

    always_ff @(posedge clk) begin
        if (enable && wr) r_mem[w_idx] <= data_in;
    end

    assign data_out = r_mem[w_idx];
endmodule

module proc #(
    parameter int                        IMEM_WORDS = 32,
    parameter logic [16*IMEM_WORDS-1:0]  PROG       = '0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_err,
    output logic [15:0] o_pc,
    output logic [15:0] o_inst,
    output logic        o_halt,
    output logic        o_reg_write,
    output logic [2:0]  o_write_reg,
    output logic [15:0] o_write_data,
    output logic        o_mem_en,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_data
);
    logic [15:0] w_pc, w_pc2, w_instr, w_next_pc;
    logic [15:0] w_rs, w_rt, w_alu, w_rdata, w_wb;
    logic [15:0] w_imm5, w_uimm5, w_imm8, w_d11;
    logic [4:0]  w_op;

    assign w_op    = w_instr[15:11];
    assign w_pc2   = w_pc + 16'd2;
    assign w_imm5  = {{11{w_instr[4]}}, w_instr[4:0]};
    assign w_uimm5 = {11'b0, w_instr[4:0]};
    assign w_imm8  = {{8{w_instr[7]}}, w_instr[7:0]};
    assign w_d11   = {{5{w_instr[10]}}, w_instr[10:0]};

    fetch #(.IMEM_WORDS(IMEM_WORDS), .PROG(PROG)) fetch0 (
        .clk(clk), .rst(rst), .i_next_pc(w_next_pc),
        .currPC(w_pc), .instr(w_instr), .halt(o_halt)
    );

    decode decode0 (
        .clk(clk), .i_instr(w_instr), .i_writedata(w_wb),
        .o_rs_val(w_rs), .o_rt_val(w_rt), .o_reg_write(o_reg_write), .o_wsel(o_write_reg),
        .o_mem_en(o_mem_en), .o_mem_wr(o_mem_wr), .o_err(o_err)
    );

    memory memory0 (
        .clk(clk), .enable(o_mem_en), .wr(o_mem_wr), .addr(w_alu),
        .data_in(w_rt), .data_out(w_rdata)
    );

    always_comb begin
        w_alu = 16'h0000;
        case (w_op)
            5'b01000, 5'b10000, 5'b10001, 5'b10011: w_alu = w_rs + w_imm5;
            5'b01001: w_alu = w_imm5 - w_rs;
            5'b01010: w_alu = w_rs ^ w_uimm5;
            5'b01011: w_alu = w_rs & ~w_uimm5;
            5'b11000: w_alu = w_imm8;
            5'b10010: w_alu = {w_rs[7:0], w_instr[7:0]};
            5'b00110, 5'b00111: w_alu = w_pc2;
            5'b11011: begin
                case (w_instr[1:0])
                    2'b00:   w_alu = w_rs + w_rt;
                    2'b01:   w_alu = w_rt - w_rs;
                    2'b10:   w_alu = w_rs ^ w_rt;
                    default: w_alu = w_rs & ~w_rt;
                endcase
            end
            default: w_alu = 16'h0000;
        endcase
    end

    // HALT holds the PC so the core idles on the halt word while still clocked.
    always_comb begin
        w_next_pc = w_pc2;
        case (w_op)
            5'b00000: w_next_pc = w_pc;
            5'b01100: if (w_rs == 16'h0000) w_next_pc = w_pc2 + w_imm8;
            5'b01101: if (w_rs != 16'h0000) w_next_pc = w_pc2 + w_imm8;
            5'b01110: if (w_rs[15])         w_next_pc = w_pc2 + w_imm8;
            5'b01111: if (!w_rs[15])        w_next_pc = w_pc2 + w_imm8;
            5'b00100, 5'b00110: w_next_pc = w_pc2 + w_d11;
            5'b00101, 5'b00111: w_next_pc = w_rs + w_imm8;
            default: w_next_pc = w_pc2;
        endcase
    end

    assign w_wb         = (w_op == 5'b10001) ? w_rdata : w_alu;
    assign o_pc         = w_pc;
    assign o_inst       = w_instr;
    assign o_write_data = w_wb;
    assign o_mem_addr   = w_alu;
    assign o_mem_data   = w_rt;
endmodule

module proc_hier_top #(
    parameter int                        CNT_W      = 32,
    parameter int                        IMEM_WORDS = 32,
    parameter logic [16*IMEM_WORDS-1:0]  PROG       = '0
) (
    input  logic              clk,
    input  logic              rst,
    proc_hier_top_if.master   tr
);
    logic             w_reg_write, w_mem_en, w_mem_wr, w_halt, w_mem_read, w_mem_write;
    logic [2:0]       w_kind;
    logic             r_halted;
    logic [CNT_W-1:0] r_cycle_count, r_inst_count;

    proc #(.IMEM_WORDS(IMEM_WORDS), .PROG(PROG)) p0 (
        .clk(clk), .rst(rst), .o_err(tr.err), .o_pc(tr.pc), .o_inst(tr.inst),
        .o_halt(w_halt), .o_reg_write(w_reg_write), .o_write_reg(tr.write_reg),
        .o_write_data(tr.write_data), .o_mem_en(w_mem_en), .o_mem_wr(w_mem_wr),
        .o_mem_addr(tr.mem_addr), .o_mem_data(tr.mem_data)
    );

    assign w_mem_read  = w_mem_en & ~w_mem_wr;
    assign w_mem_write = w_mem_en &  w_mem_wr;

    // Commit class; halt wins even if the same word also writes.
    always_comb begin
        w_kind = 3'd0;
        if (rst || r_halted)              w_kind = 3'd0;
        else if (w_halt)                  w_kind = 3'd6;
        else if (w_reg_write && w_mem_write) w_kind = 3'd3;
        else if (w_reg_write && w_mem_read)  w_kind = 3'd2;
        else if (w_reg_write)             w_kind = 3'd1;
        else if (w_mem_write)             w_kind = 3'd4;
        else                              w_kind = 3'd5;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_count <= '0;
            r_inst_count  <= '0;
            r_halted      <= 1'b0;
        end else begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (!r_halted) r_inst_count <= r_inst_count + CNT_W'(1);
            if (w_halt)    r_halted     <= 1'b1;
        end
    end

    assign tr.reg_write   = w_reg_write;
    assign tr.mem_read    = w_mem_read;
    assign tr.mem_write   = w_mem_write;
    assign tr.halt        = w_halt;
    assign tr.halted      = r_halted;
    assign tr.trace_kind  = w_kind;
    assign tr.cycle_count = r_cycle_count;
    assign tr.inst_count  = r_inst_count;
endmodule

// File: tb/tb_proc_hier_top.sv
// Directed bench for proc_hier_top: a two-word halt program with reset corner
// cases, and a table-checked program covering st/ld/stu/branch/ALU commits.
module tb_proc_hier_top;
    localparam int CNT_W = 32;

    localparam logic [511:0] PROG_A = {480'h0, 16'h0000, 16'hC112};
    localparam logic [511:0] PROG_B = {304'h0,
        16'h0000, 16'hD9B8, 16'h43A1, 16'hC577, 16'h6402, 16'hC400, 16'h9A22,
        16'h8A60, 16'h8220, 16'h9200, 16'hC201, 16'h91CD, 16'hC1AB};

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    proc_hier_top_if #(.CNT_W(CNT_W)) tr_a ();
    proc_hier_top_if #(.CNT_W(CNT_W)) tr_b ();

    proc_hier_top #(.CNT_W(CNT_W), .IMEM_WORDS(32), .PROG(PROG_A)) dut_a (
        .clk(clk), .rst(rst_a), .tr(tr_a)
    );
    proc_hier_top #(.CNT_W(CNT_W), .IMEM_WORDS(32), .PROG(PROG_B)) dut_b (
        .clk(clk), .rst(rst_b), .tr(tr_b)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
        logic [2:0]  kind;
        logic        rw;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        logic        mr;
        logic        mw;
        logic [15:0] maddr;
        logic [15:0] mdata;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{16'h0000, 16'hC1AB, 3'd1, 1'b1, 3'd1, 16'hFFAB, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{16'h0002, 16'h91CD, 3'd1, 1'b1, 3'd1, 16'hABCD, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[2]  = '{16'h0004, 16'hC201, 3'd1, 1'b1, 3'd2, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[3]  = '{16'h0006, 16'h9200, 3'd1, 1'b1, 3'd2, 16'h0100, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[4]  = '{16'h0008, 16'h8220, 3'd4, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0100, 16'hABCD};
        tbl[5]  = '{16'h000A, 16'h8A60, 3'd2, 1'b1, 3'd3, 16'hABCD, 1'b1, 1'b0, 16'h0100, 16'h0000};
        tbl[6]  = '{16'h000C, 16'h9A22, 3'd3, 1'b1, 3'd2, 16'h0102, 1'b0, 1'b1, 16'h0102, 16'hABCD};
        tbl[7]  = '{16'h000E, 16'hC400, 3'd1, 1'b1, 3'd4, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[8]  = '{16'h0010, 16'h6402, 3'd5, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[9]  = '{16'h0014, 16'h43A1, 3'd1, 1'b1, 3'd5, 16'hABCE, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[10] = '{16'h0016, 16'hD9B8, 3'd1, 1'b1, 3'd6, 16'h579B, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[11] = '{16'h0018, 16'h0000, 3'd6, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};

        // Program A: reset hold, lbi then halt, sticky halt, reset after halt.
        repeat (3) @(posedge clk);
        step();
        chk("a_rst_kind",   32'(tr_a.trace_kind), 32'd0);
        chk("a_rst_halted", 32'(tr_a.halted), 32'd0);
        chk("a_rst_cycle",  tr_a.cycle_count, 32'd0);
        chk("a_rst_inst",   tr_a.inst_count, 32'd0);
        rst_a = 1'b0;
        #1;
        chk("a_c0_kind",  32'(tr_a.trace_kind), 32'd1);
        chk("a_c0_pc",    32'(tr_a.pc), 32'h0000);
        chk("a_c0_inst",  32'(tr_a.inst), 32'hC112);
        chk("a_c0_rw",    32'(tr_a.reg_write), 32'd1);
        chk("a_c0_wreg",  32'(tr_a.write_reg), 32'd1);
        chk("a_c0_wdata", 32'(tr_a.write_data), 32'h0012);
        chk("a_c0_cycle", tr_a.cycle_count, 32'd0);
        chk("a_c0_icnt",  tr_a.inst_count, 32'd0);
        step();
        chk("a_c1_kind",  32'(tr_a.trace_kind), 32'd6);
        chk("a_c1_pc",    32'(tr_a.pc), 32'h0002);
        chk("a_c1_halt",  32'(tr_a.halt), 32'd1);
        chk("a_c1_cycle", tr_a.cycle_count, 32'd1);
        chk("a_c1_icnt",  tr_a.inst_count, 32'd1);
        chk("a_c1_halted", 32'(tr_a.halted), 32'd0);
        step();
        chk("a_c2_halted", 32'(tr_a.halted), 32'd1);
        chk("a_c2_icnt",   tr_a.inst_count, 32'd2);
        chk("a_c2_kind",   32'(tr_a.trace_kind), 32'd0);
        chk("a_c2_pc",     32'(tr_a.pc), 32'h0002);
        step();
        step();
        chk("a_c4_icnt",   tr_a.inst_count, 32'd2);
        chk("a_c4_cycle",  tr_a.cycle_count, 32'd4);
        chk("a_c4_halted", 32'(tr_a.halted), 32'd1);
        rst_a = 1'b1;
        step();
        chk("a_rr_halted", 32'(tr_a.halted), 32'd0);
        chk("a_rr_cycle",  tr_a.cycle_count, 32'd0);
        chk("a_rr_icnt",   tr_a.inst_count, 32'd0);
        chk("a_rr_kind",   32'(tr_a.trace_kind), 32'd0);
        chk("a_rr_pc",     32'(tr_a.pc), 32'h0000);
        rst_a = 1'b0;
        #1;
        chk("a_re_kind",  32'(tr_a.trace_kind), 32'd1);
        step();
        chk("a_re1_kind",  32'(tr_a.trace_kind), 32'd6);
        chk("a_re1_cycle", tr_a.cycle_count, 32'd1);
        chk("a_re1_icnt",  tr_a.inst_count, 32'd1);

        // Program B: table of one row per committed instruction.
        chk("b_rst_kind", 32'(tr_b.trace_kind), 32'd0);
        rst_b = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("b%0d_pc", i),    32'(tr_b.pc), 32'(tbl[i].pc));
            chk($sformatf("b%0d_inst", i),  32'(tr_b.inst), 32'(tbl[i].inst));
            chk($sformatf("b%0d_kind", i),  32'(tr_b.trace_kind), 32'(tbl[i].kind));
            chk($sformatf("b%0d_rw", i),    32'(tr_b.reg_write), 32'(tbl[i].rw));
            chk($sformatf("b%0d_mr", i),    32'(tr_b.mem_read), 32'(tbl[i].mr));
            chk($sformatf("b%0d_mw", i),    32'(tr_b.mem_write), 32'(tbl[i].mw));
            chk($sformatf("b%0d_err", i),   32'(tr_b.err), 32'd0);
            chk($sformatf("b%0d_cycle", i), tr_b.cycle_count, 32'(i));
            chk($sformatf("b%0d_icnt", i),  tr_b.inst_count, 32'(i));
            if (tbl[i].rw) begin
                chk($sformatf("b%0d_wreg", i),  32'(tr_b.write_reg), 32'(tbl[i].wreg));
                chk($sformatf("b%0d_wdata", i), 32'(tr_b.write_data), 32'(tbl[i].wdata));
            end
            if (tbl[i].mr || tbl[i].mw)
                chk($sformatf("b%0d_maddr", i), 32'(tr_b.mem_addr), 32'(tbl[i].maddr));
            if (tbl[i].mw)
                chk($sformatf("b%0d_mdata", i), 32'(tr_b.mem_data), 32'(tbl[i].mdata));
            step();
        end
        chk("b_end_halted", 32'(tr_b.halted), 32'd1);
        chk("b_end_icnt",   tr_b.inst_count, 32'd12);
        chk("b_end_kind",   32'(tr_b.trace_kind), 32'd0);
        chk("b_end_pc",     32'(tr_b.pc), 32'h0018);
        repeat (3) step();
        chk("b_frz_icnt",  tr_b.inst_count, 32'd12);
        chk("b_frz_cycle", tr_b.cycle_count, 32'd15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
